rr_grant_ctrl: RTL

Round-robin grant controller sharing one single-ported resource, such as a detector FSM datapath or a bus slave, among N requesters. Each requester raises `req[i]` and holds it. The controller grants exactly one requester at a time through a registered one-hot `gnt`. Ownership lasts until the owner signals `done` or drops its request. Fairness comes from a rotating priority pointer that advances past each granted requester.

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 30 +++
 rtl/rr_grant_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant controller: state encoding and defaults.
package arb_pkg;

  localparam int unsigned ARB_N_DEF       = 4;
  localparam int unsigned ARB_TIMEOUT_DEF = 16;
  localparam int unsigned ST_W            = 2;

  // Controller states; encoding 3 is illegal and recovers to ST_IDLE.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, modulo N.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   pick,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Walk the requesters starting at ptr and keep the first one found.
  always_comb begin
    logic [IDW-1:0] j_idx;
    pick  = '0;
    idx   = '0;
    any   = 1'b0;
    j_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j_idx = IDW'((32'(ptr) + i) % N);
      if (!any && req[j_idx]) begin
        any         = 1'b1;
        pick[j_idx] = 1'b1;
        idx         = j_idx;
      end
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller for one shared resource among N requesters.
// Optional ownership limit enabled by defining ARB_TIMEOUT_EN.
module rr_grant_ctrl
  import arb_pkg::*;
#(
  parameter int unsigned N       = ARB_N_DEF,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  // Reject parameter sets the controller is not designed for.
  if (N < 2 || N > 8 || IDW != $clog2(N) || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_err
    $error("rr_grant_ctrl: illegal parameterization");
  end

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           busy_q, busy_d;

  logic [N-1:0]   pick_c;
  logic [IDW-1:0] pick_idx_c;
  logic           pick_any_c;
  logic           owner_rel_c;
  logic           to_fire_c;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick_c),
    .idx  (pick_idx_c),
    .any  (pick_any_c)
  );

  // Owner-driven release: completion or abandon (both together count once).
  assign owner_rel_c = done | ~req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  assign to_fire_c = (cnt_q == 8'(TIMEOUT - 1));
  assign timeout   = timeout_q;
`else
  assign to_fire_c = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        busy_d   = 1'b0;
        if (pick_any_c) begin
          gnt_d    = pick_c;
          gnt_id_d = pick_idx_c;
          busy_d   = 1'b1;
          state_d  = ST_OWN;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = 8'd0;
`endif
        end
      end
      ST_OWN: begin
        if (owner_rel_c || to_fire_c) begin
          gnt_d    = '0;
          gnt_id_d = '0;
          busy_d   = 1'b0;
          ptr_d    = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);
          state_d  = ST_GAP;
`ifdef ARB_TIMEOUT_EN
          timeout_d = to_fire_c & ~owner_rel_c;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      ST_GAP: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Ownership counter and forced-release pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule
